// File: rtl/ec_pkg.sv
// Constants and state encoding shared by the AV1 entropy decoder and encoder.
package ec_pkg;
  localparam int          EC_MIN_PROB     = 4;
  localparam int          EC_WINDOW       = 32;
  localparam logic [15:0] EC_LOTS_OF_BITS = 16'h4000;

  typedef enum logic [2:0] {
    S_WAIT, S_INIT, S_FILL, S_IDLE, S_SEARCH, S_NORM, S_OUT
  } ec_state_e;
endpackage

// File: rtl/ec_symbol_decoder_if.sv
// Byte-in / request / inverse-CDF lookup / symbol-out bundle of the symbol decoder.
interface ec_symbol_decoder_if #(
  parameter int SYM_W = 4,
  parameter int CDF_W = 16
);
  logic             dec_start;
  logic [7:0]       in_byte;
  logic             in_valid;
  logic             in_ready;
  logic             in_eos;
  logic             req_valid;
  logic             req_ready;
  logic [SYM_W-1:0] req_nsyms_m1;
  logic [SYM_W-1:0] cdf_idx;
  logic [CDF_W-1:0] cdf_q;
  logic             sym_valid;
  logic             sym_ready;
  logic [SYM_W-1:0] symbol;
  logic             busy;

  modport master (
    output dec_start, in_byte, in_valid, in_eos, req_valid, req_nsyms_m1, cdf_q, sym_ready,
    input  in_ready, req_ready, cdf_idx, sym_valid, symbol, busy
  );
  modport slave (
    input  dec_start, in_byte, in_valid, in_eos, req_valid, req_nsyms_m1, cdf_q, sym_ready,
    output in_ready, req_ready, cdf_idx, sym_valid, symbol, busy
  );
endinterface

// File: rtl/ec_lzc16.sv
// Combinational 16-bit leading-zero count; an all-zero input reports 16.
module ec_lzc16 (
  input  logic [15:0] i_val,
  output logic [4:0]  o_cnt
);
  always_comb begin
    o_cnt = 5'd16;
    for (int i = 0; i < 16; i++)
      if (i_val[i]) o_cnt = 5'(15 - i);
  end
endmodule

// File: rtl/ec_symbol_decoder.sv
// AV1 multi-symbol arithmetic decoder: byte refill, one-entry-per-cycle inverse-CDF
// search, renormalisation, and a held symbol output.
module ec_symbol_decoder
  import ec_pkg::*;
#(
  parameter int WINDOW = EC_WINDOW,
  parameter int SYM_W  = 4,
  parameter int CDF_W  = 16
) (
  input logic               clk,
  input logic               reset,
  ec_symbol_decoder_if.slave bus
);
  ec_state_e          r_state;
  logic [WINDOW-1:0]  r_dif;
  logic [15:0]        r_rng;
  logic signed [15:0] r_cnt;
  logic [SYM_W-1:0]   r_n, r_idx, r_symbol;
  logic [7:0]         r_r;
  logic [15:0]        r_c;
  logic [17:0]        r_u;
  logic               r_sym_valid;

  logic signed [16:0] w_s;
  logic [SYM_W-1:0]   w_rem;
  logic [17:0]        w_prod, w_v;
  logic               w_c_lt_v;
  logic [4:0]         w_d;

  // Free bit positions below the window top; negative means the window is full.
  assign w_s      = 17'(WINDOW - 24) - 17'(r_cnt);
  assign w_rem    = r_n - r_idx;
  assign w_prod   = 18'(r_r) * 18'(bus.cdf_q >> 6);
  assign w_v      = (w_prod >> 1) + 18'(EC_MIN_PROB) * 18'(w_rem);
  assign w_c_lt_v = {2'b00, r_c} < w_v;

  ec_lzc16 u_lzc (.i_val(r_rng), .o_cnt(w_d));

  assign bus.in_ready  = (r_state == S_FILL) && !w_s[16];
  assign bus.req_ready = (r_state == S_IDLE);
  assign bus.busy      = (r_state != S_WAIT) && (r_state != S_IDLE);
  assign bus.cdf_idx   = r_idx;
  assign bus.sym_valid = r_sym_valid;
  assign bus.symbol    = r_symbol;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= S_WAIT;
      r_dif       <= '0;
      r_rng       <= '0;
      r_cnt       <= '0;
      r_n         <= '0;
      r_idx       <= '0;
      r_symbol    <= '0;
      r_r         <= '0;
      r_c         <= '0;
      r_u         <= '0;
      r_sym_valid <= 1'b0;
    end else if (bus.dec_start) begin
      r_state     <= S_INIT;
      r_sym_valid <= 1'b0;
    end else begin
      case (r_state)
        S_WAIT: ;
        S_INIT: begin
          r_dif   <= {1'b0, {(WINDOW-1){1'b1}}};
          r_rng   <= 16'h8000;
          r_cnt   <= -16'sd15;
          r_state <= S_FILL;
        end
        S_FILL: begin
          if (w_s[16]) begin
            r_state <= S_IDLE;
          end else if (bus.in_valid) begin
            r_dif <= r_dif ^ ({{(WINDOW-8){1'b0}}, bus.in_byte} << w_s[4:0]);
            r_cnt <= r_cnt + 16'sd8;
            // Leave as soon as the byte just taken fills the window.
            if (w_s < 17'sd8) r_state <= S_IDLE;
          end else if (bus.in_eos) begin
            r_cnt   <= EC_LOTS_OF_BITS;
            r_state <= S_IDLE;
          end
        end
        S_IDLE: begin
          if (bus.req_valid) begin
            r_n     <= bus.req_nsyms_m1;
            r_r     <= r_rng[15:8];
            r_c     <= r_dif[WINDOW-1 -: 16];
            r_u     <= {2'b00, r_rng};
            r_idx   <= '0;
            r_state <= S_SEARCH;
          end
        end
        S_SEARCH: begin
          if (w_c_lt_v) begin
            r_u   <= w_v;
            r_idx <= r_idx + 1'b1;
          end else begin
            r_symbol <= r_idx;
            r_rng    <= 16'(r_u - w_v);
            r_dif    <= r_dif - (WINDOW'(w_v) << 16);
            r_state  <= S_NORM;
          end
        end
        S_NORM: begin
          r_rng       <= r_rng << w_d;
          r_dif       <= ((r_dif + 1'b1) << w_d) - 1'b1;
          r_cnt       <= r_cnt - $signed({11'd0, w_d});
          r_sym_valid <= 1'b1;
          r_state     <= S_OUT;
        end
        S_OUT: begin
          if (bus.sym_ready) begin
            r_sym_valid <= 1'b0;
            r_state     <= (r_cnt < 0) ? S_FILL : S_IDLE;
          end
        end
        default: r_state <= S_WAIT;
      endcase
    end
  end

  // A one-symbol alphabet cannot be coded.
  always_ff @(posedge clk) begin
    if (!reset && !bus.dec_start && r_state == S_IDLE && bus.req_valid)
      assert (bus.req_nsyms_m1 != '0);
  end
endmodule

// File: tb/tb_ec_symbol_decoder.sv
// Bench for ec_symbol_decoder: directed cases plus random streams/CDFs against an
// od_ec_decode_cdf_q15-style reference model.
module tb_ec_symbol_decoder;
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  ec_symbol_decoder_if bus ();
  ec_symbol_decoder dut (.clk(clk), .reset(reset), .bus(bus));

  logic [15:0] icdf [16];
  assign bus.cdf_q = icdf[bus.cdf_idx];

  int n_checks = 0;
  int n_errs   = 0;
  byte unsigned dq[$];
  byte unsigned mq[$];
  bit  eos_flag = 1'b0;
  bit  bubbles  = 1'b0;
  int  n_bytes  = 0;

  logic [31:0] m_dif;
  int          m_rng, m_cnt;

  task automatic chk(input string tag, input longint got, input longint exp);
    n_checks++;
    if (got !== exp) begin
      n_errs++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic void m_refill();
    while (8 - m_cnt >= 0) begin
      if (mq.size() > 0) begin
        m_dif = m_dif ^ (32'(mq.pop_front()) << (8 - m_cnt));
        m_cnt += 8;
      end else begin
        m_cnt = 16384;
      end
    end
  endfunction

  function automatic void m_start();
    m_dif = 32'h7FFF_FFFF;
    m_rng = 32768;
    m_cnt = -15;
    m_refill();
  endfunction

  function automatic int m_decode(input int n);
    int c, r, u, v, ret, d;
    c = int'(m_dif >> 16);
    r = m_rng >> 8;
    v = m_rng;
    u = v;
    ret = -1;
    do begin
      u = v;
      ret++;
      v = ((r * int'(icdf[ret] >> 6)) >> 1) + 4 * (n - ret);
    end while (c < v && ret < 15);
    m_rng = u - v;
    m_dif = m_dif - (32'(v) << 16);
    d = 0;
    while (m_rng < 32768 && d < 16) begin
      m_rng = m_rng << 1;
      d++;
    end
    m_dif = ((m_dif + 32'd1) << d) - 32'd1;
    m_cnt -= d;
    if (m_cnt < 0) m_refill();
    return ret;
  endfunction

  // ---------------- stimulus helpers ----------------
  task automatic drive_in();
    bus.in_valid = (dq.size() > 0) && (!bubbles || $urandom_range(3) != 0);
    bus.in_byte  = (dq.size() > 0) ? dq[0] : 8'h00;
    bus.in_eos   = eos_flag && (dq.size() == 0);
  endtask

  // Handshake is judged on settled pre-edge values; outputs are sampled 1 after the edge.
  task automatic step();
    bit f;
    f = bus.in_valid && bus.in_ready;
    @(posedge clk);
    #1;
    if (f) begin
      void'(dq.pop_front());
      n_bytes++;
    end
    drive_in();
  endtask

  task automatic wait_idle(input string tag);
    int k = 0;
    while (!bus.req_ready && k < 300) begin
      step();
      k++;
    end
    chk({tag, "_idle"}, longint'(bus.req_ready), 1);
  endtask

  task automatic start_tile(input int nb, input byte unsigned fill, input bit rnd, input bit eos);
    byte unsigned q[$];
    for (int i = 0; i < nb; i++) q.push_back(rnd ? byte'($urandom_range(255)) : fill);
    bus.dec_start = 1'b1;
    dq.delete();
    eos_flag = 1'b0;
    drive_in();
    step();
    bus.dec_start = 1'b0;
    dq = q;
    mq = q;
    eos_flag = eos;
    m_start();
    drive_in();
  endtask

  task automatic rand_icdf(input int n);
    int vals[$];
    for (int i = 0; i < 16; i++) icdf[i] = 16'd0;
    for (int i = 0; i < n; i++) vals.push_back(int'($urandom_range(32767)));
    vals.rsort();
    for (int i = 0; i < n; i++) icdf[i] = 16'(vals[i]);
  endtask

  task automatic lin_icdf();
    for (int i = 0; i < 16; i++) icdf[i] = (i < 15) ? 16'(32768 - (i + 1) * 2048) : 16'd0;
  endtask

  task automatic do_req(input string tag, input int n, input int bp, input int exp_fixed);
    int sym, lat;
    logic [3:0] held;
    wait_idle(tag);
    chk({tag, "_dif"}, longint'(dut.r_dif), longint'(m_dif));
    chk({tag, "_rng"}, longint'(dut.r_rng), longint'(m_rng));
    chk({tag, "_cnt"}, longint'(dut.r_cnt), longint'(m_cnt));
    bus.req_valid    = 1'b1;
    bus.req_nsyms_m1 = 4'(n);
    step();
    bus.req_valid = 1'b0;
    sym = m_decode(n);
    lat = 0;
    while (!bus.sym_valid && lat < 40) begin
      step();
      lat++;
    end
    chk({tag, "_lat"}, lat, sym + 2);
    chk({tag, "_sym"}, longint'(bus.symbol), sym);
    if (exp_fixed >= 0) chk({tag, "_symk"}, longint'(bus.symbol), exp_fixed);
    held = bus.symbol;
    for (int i = 0; i < bp; i++) begin
      step();
      chk({tag, "_bp_vld"}, longint'(bus.sym_valid), 1);
      chk({tag, "_bp_sym"}, longint'(bus.symbol), longint'(held));
      chk({tag, "_bp_rrdy"}, longint'(bus.req_ready), 0);
      chk({tag, "_bp_irdy"}, longint'(bus.in_ready), 0);
    end
    bus.sym_ready = 1'b1;
    step();
    bus.sym_ready = 1'b0;
    chk({tag, "_acc"}, longint'(bus.sym_valid), 0);
  endtask

  task automatic test_init(input string tag);
    int base, k;
    start_tile(4, 8'h00, 1'b0, 1'b0);
    base = n_bytes;
    k = 0;
    while (n_bytes - base < 3 && k < 20) begin
      step();
      k++;
    end
    chk({tag, "_rrdy"}, longint'(bus.req_ready), 1);
    chk({tag, "_irdy"}, longint'(bus.in_ready), 0);
    for (int i = 0; i < 3; i++) step();
    chk({tag, "_nbytes"}, n_bytes - base, 3);
    chk({tag, "_left"}, dq.size(), 1);
    chk({tag, "_dif"}, longint'(dut.r_dif), 64'h7FFF_FFFF);
    chk({tag, "_cnt"}, longint'(dut.r_cnt), 9);
    chk({tag, "_rng"}, longint'(dut.r_rng), 64'h8000);
  endtask

  task automatic check_reset_outs(input string tag);
    chk({tag, "_irdy"}, longint'(bus.in_ready), 0);
    chk({tag, "_rrdy"}, longint'(bus.req_ready), 0);
    chk({tag, "_svld"}, longint'(bus.sym_valid), 0);
    chk({tag, "_sym"}, longint'(bus.symbol), 0);
    chk({tag, "_idx"}, longint'(bus.cdf_idx), 0);
    chk({tag, "_busy"}, longint'(bus.busy), 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    bus.dec_start    = 1'b0;
    bus.req_valid    = 1'b0;
    bus.req_nsyms_m1 = 4'd1;
    bus.sym_ready    = 1'b0;
    for (int i = 0; i < 16; i++) icdf[i] = 16'd0;
    drive_in();
    step();
    step();
    check_reset_outs("rst");
    reset = 1'b0;
    step();

    // Init with zero bytes, then a binary decode that keeps symbol 0.
    test_init("t1");
    icdf[0] = 16'd16384;
    icdf[1] = 16'd0;
    do_req("t2", 1, 0, 0);
    wait_idle("t2b");
    chk("t2_rng", longint'(dut.r_rng), 65520);
    chk("t2_cnt", longint'(dut.r_cnt), 7);

    // All-ones bytes drive c to 0: symbol 1, with held-off acceptance.
    start_tile(3, 8'hFF, 1'b0, 1'b0);
    wait_idle("t3");
    chk("t3_dif", longint'(dut.r_dif), 64'h7F);
    do_req("t3", 1, 5, 1);
    wait_idle("t3b");
    chk("t3_rng", longint'(dut.r_rng), 32776);

    // Stream exhausted immediately: decoding continues on lots-of-bits.
    start_tile(0, 8'h00, 1'b0, 1'b1);
    wait_idle("t5");
    chk("t5_cnt", longint'(dut.r_cnt), 16384);
    for (int i = 0; i < 20; i++) begin
      int n;
      n = int'($urandom_range(15, 1));
      rand_icdf(n);
      do_req("t5r", n, int'($urandom_range(2)), -1);
    end

    // Random tiles with input bubbles and refills mid-tile.
    bubbles = 1'b1;
    for (int t = 0; t < 3; t++) begin
      start_tile(48, 8'h00, 1'b1, 1'b1);
      for (int i = 0; i < 25; i++) begin
        int n;
        n = int'($urandom_range(15, 1));
        rand_icdf(n);
        do_req("rnd", n, int'($urandom_range(3)), -1);
      end
    end
    bubbles = 1'b0;

    // Reset in the middle of a long search, then replay init and a full-length sweep.
    lin_icdf();
    start_tile(3, 8'hFF, 1'b0, 1'b0);
    wait_idle("t6");
    bus.req_valid    = 1'b1;
    bus.req_nsyms_m1 = 4'd15;
    step();
    bus.req_valid = 1'b0;
    for (int i = 0; i < 3; i++) step();
    chk("t6_busy", longint'(bus.busy), 1);
    chk("t6_idx", longint'(bus.cdf_idx), 3);
    reset = 1'b1;
    step();
    check_reset_outs("t6rst");
    reset = 1'b0;
    test_init("t6i");
    lin_icdf();
    start_tile(3, 8'hFF, 1'b0, 1'b0);
    do_req("t6sw", 15, 0, 15);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errs);
    $finish;
  end
endmodule
